// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
//   RESET_PC       : address the PC register loads on reset
//   fetch_entry_t  : decode-queue entry {pc, instr, misalign}
//   fetch_tag_t    : per-request tag {pc, misalign} held while a fetch is in flight
//   word_addr()    : aligns a PC down to its 32-bit word address
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misalign;
  } fetch_entry_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        misalign;
  } fetch_tag_t;

  function automatic logic [31:0] word_addr(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a one-cycle flush.
//   clk, rst_n : clock, async active-low reset (clears pointers, count and storage)
//   flush      : empties the FIFO; push/pop in the same cycle are ignored
//   push/wdata : write one entry
//   pop        : drop the head entry (caller guarantees count != 0)
//   rdata      : registered head entry
//   count      : occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap for free.
module fetch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count
);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      // Storage is left stale; count=0 hides it from the consumer.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage between the PC register and decode.
//   pc_in / pc_ena               : current PC in, advance enable out (one pulse per accepted fetch)
//   flush                        : redirect pulse; drops queued entries and in-flight fetches
//   imem_req_* / imem_rsp_*      : in-order instruction memory, responses always accepted
//   if_valid/if_ready/if_pc/
//   if_instr/if_misalign         : registered queue head handed to decode
// Credit: queued + outstanding + stale responses never exceed DEPTH, so neither
// FIFO can overflow and stale responses keep holding their slot until drained.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_in,
  output logic        pc_ena,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_misalign
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] count, outstanding, drop;
  logic [CW+1:0] credit_used;
  logic          rsp_keep, dec_pop;
  fetch_tag_t    tag_in, tag_head;
  fetch_entry_t  ent_in, ent_head;

  assign credit_used    = (CW+2)'(count) + (CW+2)'(outstanding) + (CW+2)'(drop);
  assign imem_req_valid = !flush && (credit_used < (CW+2)'(DEPTH));
  assign pc_ena         = imem_req_valid && imem_req_ready;
  assign imem_req_addr  = word_addr(pc_in);

  // A response is kept only if no stale ones are ahead of it and no redirect is happening now.
  assign rsp_keep = imem_rsp_valid && (drop == '0) && !flush;
  assign if_valid = (count != '0);
  assign dec_pop  = if_valid && if_ready;

  assign tag_in = {pc_in, (pc_in[1:0] != 2'b00)};
  assign ent_in = {tag_head.pc, imem_rsp_data, tag_head.misalign};

  // Tag FIFO: one entry per accepted request; its occupancy is the outstanding count.
  fetch_fifo #(.W($bits(fetch_tag_t)), .DEPTH(DEPTH)) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (pc_ena),
    .wdata (tag_in),
    .pop   (rsp_keep),
    .rdata (tag_head),
    .count (outstanding)
  );

  fetch_fifo #(.W($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_entry_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (rsp_keep),
    .wdata (ent_in),
    .pop   (dec_pop),
    .rdata (ent_head),
    .count (count)
  );

  // On redirect every in-flight fetch becomes stale, minus one if it returns this very cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop <= '0;
    else if (flush)
      drop <= drop + outstanding - CW'(imem_rsp_valid);
    else if (imem_rsp_valid && (drop != '0))
      drop <= drop - CW'(1);
  end

  assign if_pc       = ent_head.pc;
  assign if_instr    = ent_head.instr;
  assign if_misalign = ent_head.misalign;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: a PC register and a variable-latency
// in-order memory around the DUT, checked every cycle against a queue-based model.
module tb_ifetch_unit;
  import cpu_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_in;
  logic        pc_ena;
  logic        flush;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr;
  logic        if_misalign;

  ifetch_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .pc_in(pc_in), .pc_ena(pc_ena), .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr), .if_misalign(if_misalign)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model state
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic mis; } ent_t;
  typedef struct { logic [31:0] pc; logic mis; } tag_t;
  typedef struct { int due; logic [31:0] addr; } mreq_t;

  ent_t        mq[$];
  tag_t        mt[$];
  int          mdrop;
  mreq_t       mem[$];
  logic [31:0] pcr;
  int          rdy_pct, mrdy_pct, lat_min, lat_max;

  // Last-cycle DUT observations for directed checks
  logic        o_req, o_ena, o_valid, o_pop, o_mis;
  logic [31:0] o_addr, o_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  function automatic bit rsp_due();
    return mem.size() != 0 && mem[0].due <= cyc;
  endfunction

  // One clock cycle: drive inputs, check at negedge, advance model at posedge.
  task automatic drive(input bit fl, input logic [31:0] tgt);
    bit          exp_req, acc, pop, rv;
    logic [31:0] rd;
    tag_t        t;
    flush          = fl;
    if_ready       = ($urandom_range(99) < rdy_pct);
    imem_req_ready = ($urandom_range(99) < mrdy_pct);
    pc_in          = pcr;
    rv             = rst_n && rsp_due();
    rd             = rv ? mem_word(mem[0].addr) : $urandom;
    imem_rsp_valid = rv;
    imem_rsp_data  = rd;
    @(negedge clk);
    exp_req = !fl && (mq.size() + mt.size() + mdrop < DEPTH);
    o_req = imem_req_valid; o_ena = pc_ena; o_addr = imem_req_addr;
    o_valid = if_valid; o_pop = if_valid && if_ready; o_pc = if_pc; o_mis = if_misalign;
    if (!rst_n) begin
      chk("rst_if_valid", if_valid, 0);
      chk("rst_if_pc", if_pc, 0);
      chk("rst_if_instr", if_instr, 0);
    end else begin
      chk("req_valid", imem_req_valid, exp_req);
      chk("pc_ena", pc_ena, exp_req && imem_req_ready);
      if (exp_req) chk("req_addr", imem_req_addr, {pcr[31:2], 2'b00});
      chk("if_valid", if_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("if_pc", if_pc, mq[0].pc);
        chk("if_instr", if_instr, mq[0].instr);
        chk("if_misalign", if_misalign, mq[0].mis);
      end
    end
    acc = exp_req && imem_req_ready;
    pop = mq.size() != 0 && if_ready;
    @(posedge clk);
    if (!rst_n) begin
      mq.delete(); mt.delete(); mem.delete(); mdrop = 0; pcr = RESET_PC;
    end else begin
      if (rv) void'(mem.pop_front());
      if (fl) begin
        mdrop = mdrop + mt.size() - (rv ? 1 : 0);
        mq.delete(); mt.delete();
        pcr = tgt;
      end else begin
        if (pop) void'(mq.pop_front());
        if (rv) begin
          if (mdrop > 0) mdrop--;
          else begin
            t = mt.pop_front();
            mq.push_back('{pc: t.pc, instr: rd, mis: t.mis});
          end
        end
        if (acc) begin
          mt.push_back('{pc: pcr, mis: (pcr[1:0] != 2'b00)});
          mem.push_back('{due: cyc + $urandom_range(lat_max, lat_min), addr: {pcr[31:2], 2'b00}});
          pcr = pcr + 32'd4;
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) drive(0, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          first_ena, first_val, npop, nena, k;
    logic [31:0] ppc[3];
    int          pcy[3];
    bit          hit;
    rst_n = 1'b0; flush = 1'b0; if_ready = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; pc_in = RESET_PC;
    pcr = RESET_PC; mdrop = 0;
    rdy_pct = 100; mrdy_pct = 100; lat_min = 1; lat_max = 1;
    @(posedge clk); #1;
    repeat (3) drive(0, 0);

    // Straight-line fetch out of reset
    rst_n = 1'b1;
    first_ena = -1; first_val = -1; npop = 0;
    for (int i = 0; i < 12; i++) begin
      drive(0, 0);
      if (o_ena && first_ena < 0) first_ena = i;
      if (o_valid && first_val < 0) first_val = i;
      if (o_pop && npop < 3) begin ppc[npop] = o_pc; pcy[npop] = i; npop++; end
    end
    chk("first_req_cycle", first_ena, 0);
    chk("first_valid_lat", first_val - first_ena, 2);
    chk("sl_pc0", ppc[0], 32'h0040_0000);
    chk("sl_pc1", ppc[1], 32'h0040_0004);
    chk("sl_pc2", ppc[2], 32'h0040_0008);
    chk("sl_gap1", pcy[1] - pcy[0], 1);
    chk("sl_gap2", pcy[2] - pcy[1], 1);

    // Backpressure: exactly DEPTH fetches, then stall, then in-order drain
    do_reset();
    rdy_pct = 0; nena = 0;
    for (int i = 0; i < 10; i++) begin drive(0, 0); nena += o_ena; end
    chk("bp_ena_count", nena, DEPTH);
    chk("bp_req_stalled", o_req, 0);
    rdy_pct = 100; k = 0;
    for (int i = 0; i < 10 && k < DEPTH; i++) begin
      drive(0, 0);
      if (o_pop) begin chk("bp_drain_pc", o_pc, RESET_PC + 32'(4 * k)); k++; end
    end
    chk("bp_drain_count", k, DEPTH);

    // Flush with two fetches in flight, latency 3
    do_reset();
    lat_min = 3; lat_max = 3;
    drive(0, 0); drive(0, 0);
    drive(1, 32'h0040_0100);
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      drive(0, 0);
      if (o_pop) begin chk("flush_first_pc", o_pc, 32'h0040_0100); hit = 1; end
    end
    chk("flush_pop_seen", hit, 1);

    // Flush coincident with a response and a decode pop, latency 2
    do_reset();
    lat_min = 2; lat_max = 2; hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (i > 3 && rsp_due() && mq.size() != 0) begin drive(1, 32'h0040_0200); hit = 1; end
      else drive(0, 0);
    end
    chk("coinc_found", hit, 1);
    drive(0, 0);
    chk("coinc_no_valid", o_valid, 0);
    repeat (8) drive(0, 0);

    // Misaligned redirect target
    drive(1, 32'h0040_0002);
    drive(0, 0);
    chk("mis_req_addr", o_addr, 32'h0040_0000);
    hit = 0;
    for (int i = 0; i < 30 && !hit; i++) begin
      if (o_pop) begin
        chk("mis_pc", o_pc, 32'h0040_0002);
        chk("mis_flag", o_mis, 1);
        hit = 1;
      end else drive(0, 0);
    end
    chk("mis_pop_seen", hit, 1);

    // Asynchronous reset with a full queue
    rdy_pct = 0; lat_min = 1; lat_max = 1;
    for (int i = 0; i < 20 && mq.size() != DEPTH; i++) drive(0, 0);
    drive(0, 0);
    chk("full_valid", o_valid, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_valid", if_valid, 0);
    drive(0, 0); drive(0, 0);
    rst_n = 1'b1; rdy_pct = 100;
    drive(0, 0);
    chk("restart_req", o_req, 1);
    chk("restart_addr", o_addr, RESET_PC);

    // Random traffic
    rdy_pct = 70; mrdy_pct = 75; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 3)
        drive(1, RESET_PC + ($urandom_range(1023) << 2) + (($urandom_range(7) == 0) ? 32'd2 : 32'd0));
      else
        drive(0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
